// File: rtl/rc_filter_channel_scheduler_if.sv
// Bus bundle for rc_filter_channel_scheduler: sample strobe, packed voice I/O, alpha config port, status.
// overrun_count exists only when SCHED_OVERRUN_CNT_EN is defined.
interface rc_filter_channel_scheduler_if #(
  parameter int CHANNELS = 4
);
  logic                    audio_clk_en;
  logic [16*CHANNELS-1:0]  in_bus;
  logic                    cfg_we;
  logic [3:0]              cfg_ch;
  logic [15:0]             cfg_alpha;
  logic [16*CHANNELS-1:0]  out_bus;
  logic                    out_valid;
  logic                    busy;
  logic                    overrun;
`ifdef SCHED_OVERRUN_CNT_EN
  logic [15:0]             overrun_count;
`endif

  modport master (
    output audio_clk_en, in_bus, cfg_we, cfg_ch, cfg_alpha,
`ifdef SCHED_OVERRUN_CNT_EN
    input  overrun_count,
`endif
    input  out_bus, out_valid, busy, overrun
  );

  modport slave (
    input  audio_clk_en, in_bus, cfg_we, cfg_ch, cfg_alpha,
`ifdef SCHED_OVERRUN_CNT_EN
    output overrun_count,
`endif
    output out_bus, out_valid, busy, overrun
  );
endinterface

// File: rtl/rc_filter_channel_scheduler.sv
// One shared single-pole leaky RC low-pass datapath stepped across CHANNELS voices per sample strobe.
// Optional feature macro: SCHED_OVERRUN_CNT_EN (adds saturating overrun_count output).
module rc_filter_channel_scheduler #(
  parameter int CHANNELS      = 4,
  parameter int CLOCK_RATE    = 50000000,
  parameter int SAMPLE_RATE   = 48000,
  parameter int ALPHA_DEFAULT = 1638,
  parameter int LEAK_11       = 2048
) (
  input  logic clk,
  input  logic reset_n,
  rc_filter_channel_scheduler_if.slave sched
);

  localparam int              CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [15:0]     ALPHA_RST = 16'(ALPHA_DEFAULT);
  localparam logic [11:0]     LEAK_W    = 12'(LEAK_11);
  localparam logic [CW-1:0]   LAST_CH   = CW'(CHANNELS - 1);

  generate
    if ((2 * CHANNELS + 2) > (CLOCK_RATE / SAMPLE_RATE)) begin : g_rate_check
      $error("rc_filter_channel_scheduler: sequence does not fit in one sample period");
    end
    if ((CHANNELS < 1) || (CHANNELS > 16) || (LEAK_11 < 0) || (LEAK_11 > 2048)) begin : g_param_check
      $error("rc_filter_channel_scheduler: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ACC, S_PUBLISH} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_ch;
  logic signed [15:0]      r_x         [CHANNELS];
  logic signed [15:0]      r_y         [CHANNELS];
  logic [15:0]             r_alpha_act [CHANNELS];
  logic [15:0]             r_alpha_shd [CHANNELS];
  logic signed [33:0]      r_p;
  logic signed [28:0]      r_l;
  logic [16*CHANNELS-1:0]  r_out_bus;
  logic                    r_out_valid;
  logic                    r_busy;
  logic                    r_overrun;

  logic signed [16:0]      w_d;
  logic signed [33:0]      w_p;
  logic signed [28:0]      w_l;
  logic signed [33:0]      w_l_ext;
  logic signed [33:0]      w_sum;
  logic signed [15:0]      w_y_next;
  logic [16*CHANNELS-1:0]  w_y_flat;
  logic                    w_drop;

  // Shared multiplier pair; alpha is unsigned so it is zero-extended into the signed product.
  assign w_d     = {r_x[r_ch][15], r_x[r_ch]} - {r_y[r_ch][15], r_y[r_ch]};
  assign w_p     = $signed({1'b0, r_alpha_act[r_ch]}) * w_d;
  assign w_l     = $signed({1'b0, LEAK_W}) * r_y[r_ch];
  assign w_l_ext = 34'(r_l);
  assign w_sum   = (w_l_ext >>> 11) + (r_p >>> 16);
  assign w_drop  = sched.audio_clk_en && (r_state != S_IDLE);

  // Saturate the accumulated update to the 16-bit signed state range.
  always_comb begin
    w_y_next = w_sum[15:0];
    if (w_sum > 34'sd32767) begin
      w_y_next = 16'sh7FFF;
    end else if (w_sum < -34'sd32768) begin
      w_y_next = 16'sh8000;
    end else begin
      w_y_next = w_sum[15:0];
    end
  end

  // Flatten filter states for the single-cycle publish.
  always_comb begin
    w_y_flat = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_y_flat[16*k +: 16] = r_y[k];
    end
  end

  // Host alpha writes land in the shadow bank only; out-of-range channel indices are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_alpha_shd[k] <= ALPHA_RST;
      end
    end else if (sched.cfg_we && (int'(sched.cfg_ch) < CHANNELS)) begin
      r_alpha_shd[sched.cfg_ch[CW-1:0]] <= sched.cfg_alpha;
    end
  end

  // Sequencer: snapshot, per-channel CALC/ACC steps, then atomic publish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_p         <= '0;
      r_l         <= '0;
      r_out_bus   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        r_x[k]         <= '0;
        r_y[k]         <= '0;
        r_alpha_act[k] <= ALPHA_RST;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_overrun   <= w_drop;
      case (r_state)
        S_IDLE: begin
          if (sched.audio_clk_en) begin
            for (int k = 0; k < CHANNELS; k++) begin
              r_x[k]         <= $signed(sched.in_bus[16*k +: 16]);
              r_alpha_act[k] <= r_alpha_shd[k];
            end
            r_ch    <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_p     <= w_p;
          r_l     <= w_l;
          r_state <= S_ACC;
        end
        S_ACC: begin
          r_y[r_ch] <= w_y_next;
          if (r_ch == LAST_CH) begin
            r_state <= S_PUBLISH;
          end else begin
            r_ch    <= r_ch + CW'(1);
            r_state <= S_CALC;
          end
        end
        S_PUBLISH: begin
          r_out_bus   <= w_y_flat;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SCHED_OVERRUN_CNT_EN
  logic [15:0] r_overrun_count;

  // Dropped-strobe counter, saturating at all-ones, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun_count <= 16'd0;
    end else if (w_drop && (r_overrun_count != 16'hFFFF)) begin
      r_overrun_count <= r_overrun_count + 16'd1;
    end
  end

  assign sched.overrun_count = r_overrun_count;
`endif

  assign sched.out_bus   = r_out_bus;
  assign sched.out_valid = r_out_valid;
  assign sched.busy      = r_busy;
  assign sched.overrun   = r_overrun;

endmodule

// File: tb/tb_rc_filter_channel_scheduler.sv
// Scoreboard bench for rc_filter_channel_scheduler: a main DUT (LEAK_11=2048) checked against a
// reference filter model, plus a lockstep leaky DUT (LEAK_11=1024) checked against fixed values.
module tb_rc_filter_channel_scheduler;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rc_filter_channel_scheduler_if #(.CHANNELS(CH)) m ();
  rc_filter_channel_scheduler_if #(.CHANNELS(CH)) lk ();

  assign lk.audio_clk_en = m.audio_clk_en;
  assign lk.in_bus       = m.in_bus;

  rc_filter_channel_scheduler #(
    .CHANNELS(CH), .CLOCK_RATE(50000000), .SAMPLE_RATE(48000),
    .ALPHA_DEFAULT(1638), .LEAK_11(2048)
  ) u_dut (.clk(clk), .reset_n(reset_n), .sched(m.slave));

  rc_filter_channel_scheduler #(
    .CHANNELS(CH), .CLOCK_RATE(50000000), .SAMPLE_RATE(48000),
    .ALPHA_DEFAULT(1638), .LEAK_11(1024)
  ) u_leak (.clk(clk), .reset_n(reset_n), .sched(lk.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0]   m_y   [CH];
  logic [15:0]          m_sh  [CH];
  logic [15:0]          m_act [CH];
  logic [16*CH-1:0]     exp_q [$];

  function automatic logic signed [15:0] model_step(input logic signed [15:0] x,
                                                     input logic signed [15:0] y,
                                                     input logic [15:0] a, input int leak);
    longint xi, yi, ai, s;
    xi = x; yi = y; ai = a;
    s = ((longint'(leak) * yi) >>> 11) + ((ai * (xi - yi)) >>> 16);
    if (s > 32767) return 16'sh7FFF;
    if (s < -32768) return 16'sh8000;
    return s[15:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_y[k] = 16'sd0; m_sh[k] = 16'd1638; m_act[k] = 16'd1638;
    end
    exp_q.delete();
  endtask

  // Called in the cycle a strobe is presented to an idle DUT.
  task automatic model_accept();
    logic [16*CH-1:0] e;
    for (int k = 0; k < CH; k++) begin
      m_act[k] = m_sh[k];
      m_y[k]   = model_step($signed(m.in_bus[16*k +: 16]), m_y[k], m_act[k], 2048);
      e[16*k +: 16] = m_y[k];
    end
    exp_q.push_back(e);
  endtask

  task automatic set_in(input int k, input logic [15:0] v);
    m.in_bus[16*k +: 16] = v;
  endtask

  task automatic cfg_write(input logic [3:0] ch, input logic [15:0] a);
    m.cfg_we = 1'b1; m.cfg_ch = ch; m.cfg_alpha = a;
    @(posedge clk); #1;
    m.cfg_we = 1'b0;
    if (ch < 4'd4) m_sh[ch[1:0]] = a;
  endtask

  task automatic lk_cfg_write(input logic [3:0] ch, input logic [15:0] a);
    lk.cfg_we = 1'b1; lk.cfg_ch = ch; lk.cfg_alpha = a;
    @(posedge clk); #1;
    lk.cfg_we = 1'b0;
  endtask

  // Pulses the strobe for one cycle and waits (bounded) for out_valid; lat = -1 on timeout.
  task automatic run_sample(output logic [16*CH-1:0] got, output int lat);
    m.audio_clk_en = 1'b1;
    @(posedge clk); #1;
    m.audio_clk_en = 1'b0;
    m.cfg_we = 1'b0;
    lat = -1;
    got = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (m.out_valid === 1'b1) begin
        lat = i; got = m.out_bus;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m.audio_clk_en = 1'b0; m.cfg_we = 1'b0; lk.cfg_we = 1'b0; m.in_bus = '0;
    @(posedge clk); #1;
    model_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (m.out_bus !== 64'd0) begin n_fail++; $display("FAIL reset_out_bus: got %h expected 0", m.out_bus); end
    n_checks++; if (m.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", m.out_valid); end
    n_checks++; if (m.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", m.busy); end
    n_checks++; if (m.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", m.overrun); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_step_response();
    logic [16*CH-1:0] got, e;
    int lat;
    logic [15:0] want [3];
    want[0] = 16'd8192; want[1] = 16'd12288; want[2] = 16'd14336;
    set_in(0, 16'd16384);
    cfg_write(4'd0, 16'd32768);
    for (int s = 0; s < 3; s++) begin
      if (s == 1) begin
        cfg_write(4'd4, 16'd0);
        cfg_write(4'd12, 16'd0);
      end
      model_accept();
      run_sample(got, lat);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL step_bus s%0d: got %h expected %h", s, got, e); end
      n_checks++; if (lat != 9) begin n_fail++; $display("FAIL step_latency s%0d: got %0d expected 9", s, lat); end
      n_checks++; if (got[15:0] !== want[s]) begin n_fail++; $display("FAIL step_ch0 s%0d: got %0d expected %0d", s, got[15:0], want[s]); end
      repeat (20) @(posedge clk);
      #1;
      n_checks++; if (m.out_bus !== got) begin n_fail++; $display("FAIL step_hold s%0d: got %h expected %h", s, m.out_bus, got); end
    end
  endtask

  task automatic test_channel_isolation();
    logic [16*CH-1:0] got, e;
    int lat;
    do_reset();
    set_in(1, 16'hC000);
    cfg_write(4'd1, 16'd65535);
    model_accept();
    run_sample(got, lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL iso_bus: got %h expected %h", got, e); end
    n_checks++; if (got !== 64'h0000_0000_C000_0000) begin n_fail++; $display("FAIL iso_const: got %h expected 00000000c0000000", got); end
  endtask

  task automatic test_overrun();
    logic [16*CH-1:0] e;
    int n_ovr, n_val;
    n_ovr = 0; n_val = 0;
    m.audio_clk_en = 1'b1;
    model_accept();
    @(posedge clk); #1;
    m.audio_clk_en = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      m.audio_clk_en = (i == 3);
      @(posedge clk); #1;
      if (m.overrun === 1'b1) n_ovr++;
      if (i == 2) begin
        n_checks++; if (m.busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy: got %b expected 1", m.busy); end
      end
      if (m.out_valid === 1'b1) begin
        n_val++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++; if (m.out_bus !== e) begin n_fail++; $display("FAIL ovr_bus: got %h expected %h", m.out_bus, e); end
      end
    end
    m.audio_clk_en = 1'b0;
    n_checks++; if (n_ovr != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", n_ovr); end
    n_checks++; if (n_val != 1) begin n_fail++; $display("FAIL ovr_valids: got %0d expected 1", n_val); end
`ifdef SCHED_OVERRUN_CNT_EN
    n_checks++; if (m.overrun_count !== 16'd1) begin n_fail++; $display("FAIL ovr_count: got %0d expected 1", m.overrun_count); end
`endif
  endtask

  task automatic test_cfg_while_busy();
    logic [16*CH-1:0] got, e;
    int lat;
    logic [15:0] want [4];
    want[0] = 16'd8192; want[1] = 16'd8192; want[2] = 16'd8192; want[3] = 16'd12288;
    do_reset();
    set_in(0, 16'd16384);
    cfg_write(4'd0, 16'd32768);
    for (int s = 0; s < 4; s++) begin
      if (s == 2) begin
        m.cfg_we = 1'b1; m.cfg_ch = 4'd0; m.cfg_alpha = 16'd32768;
      end
      model_accept();
      if (s == 2) m_sh[0] = 16'd32768;
      if (s == 0) begin
        fork
          run_sample(got, lat);
          begin
            repeat (3) @(posedge clk);
            #1;
            cfg_write(4'd0, 16'd0);
          end
        join
      end else begin
        run_sample(got, lat);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL cfg_bus s%0d: got %h expected %h", s, got, e); end
      n_checks++; if (got[15:0] !== want[s]) begin n_fail++; $display("FAIL cfg_ch0 s%0d: got %0d expected %0d", s, got[15:0], want[s]); end
    end
  endtask

  task automatic test_reset_mid_sequence();
    logic [16*CH-1:0] got, e;
    int lat;
    m.audio_clk_en = 1'b1;
    model_accept();
    @(posedge clk); #1;
    m.audio_clk_en = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (m.out_bus !== 64'd0) begin n_fail++; $display("FAIL rst_mid_bus: got %h expected 0", m.out_bus); end
    n_checks++; if (m.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", m.busy); end
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    cfg_write(4'd0, 16'd32768);
    model_accept();
    run_sample(got, lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL rst_mid_fresh: got %h expected %h", got, e); end
    n_checks++; if (got[15:0] !== 16'd8192 || lat != 9) begin n_fail++; $display("FAIL rst_mid_ch0: got %0d lat %0d expected 8192 lat 9", got[15:0], lat); end
  endtask

  task automatic test_leak();
    logic [16*CH-1:0] got, e;
    int lat;
    logic [15:0] want [4];
    want[0] = 16'd8192; want[1] = 16'd4096; want[2] = 16'd2048; want[3] = 16'd1024;
    do_reset();
    set_in(0, 16'd16384);
    lk_cfg_write(4'd0, 16'd32768);
    for (int s = 0; s < 4; s++) begin
      if (s == 1) lk_cfg_write(4'd0, 16'd0);
      model_accept();
      run_sample(got, lat);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL leak_main_bus s%0d: got %h expected %h", s, got, e); end
      n_checks++; if (lk.out_bus[15:0] !== want[s]) begin n_fail++; $display("FAIL leak_ch0 s%0d: got %0d expected %0d", s, lk.out_bus[15:0], want[s]); end
      n_checks++; if (lk.out_bus[63:16] !== 48'd0) begin n_fail++; $display("FAIL leak_others s%0d: got %h expected 0", s, lk.out_bus[63:16]); end
    end
  endtask

  initial begin
    m.audio_clk_en = 1'b0; m.in_bus = '0; m.cfg_we = 1'b0; m.cfg_ch = 4'd0; m.cfg_alpha = 16'd0;
    lk.cfg_we = 1'b0; lk.cfg_ch = 4'd0; lk.cfg_alpha = 16'd0;
    model_reset();
    test_reset();
    test_step_response();
    test_channel_isolation();
    test_overrun();
    test_cfg_while_busy();
    test_reset_mid_sequence();
    test_leak();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL queue_drained: got %0d entries expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
